// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C write-only target receiver.
// Pure declarations: no latency, no flow control.
package i2c_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    ADDR_ACK,
    DATA,
    DATA_ACK,
    IGNORE
  } i2c_tgt_state_t;

  localparam logic       I2C_RW_WRITE  = 1'b0;
  localparam logic       I2C_ACK       = 1'b0;
  localparam logic [3:0] BITS_PER_BYTE = 4'd8;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/i2c_line_sync.sv
// Bus line synchronizer with a registered previous sample for edge detection.
// Level lags the pin by STAGES clocks; rise/fall are combinational off the synchronized level.
module i2c_line_sync #(
  parameter int STAGES = 2
) (
  input  logic i_clk,
  input  logic i_nrst,
  input  logic pin,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] sync_q;
  logic              prev_q;

  // Reset to 1 so an idle (pulled-up) bus produces no edge when reset is released.
  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      sync_q <= '1;
      prev_q <= 1'b1;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], pin};
      prev_q <= sync_q[STAGES-1];
    end
  end

  assign level = sync_q[STAGES-1];
  assign rise  = level & ~prev_q;
  assign fall  = ~level & prev_q;

endmodule

// File: rtl/i2c_target_rx.sv
// I2C write-only target: address match, ACK/NACK on SDA, one-cycle valid per accepted byte.
// o_rx_valid 1 clk after the synchronized SCL fall ending bit 8; i_rx_ready=0 NACKs the byte.
module i2c_target_rx
  import i2c_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int ADDR_W      = 7
) (
  input  logic              i_clk,
  input  logic              i_nrst,
  input  logic [ADDR_W-1:0] i_own_addr,
  input  logic              i_rx_ready,
  output logic [7:0]        o_rx_data,
  output logic              o_rx_valid,
  output logic              o_rx_first,
  output logic [7:0]        o_byte_cnt,
  output logic              o_busy,
  output logic              o_addr_hit,
  inout  wire               o_scl,
  inout  wire               o_sda
);

  logic scl_s, scl_rise, scl_fall;
  logic sda_s, sda_rise, sda_fall;
  logic start_det, stop_det;

  i2c_line_sync #(.STAGES(SYNC_STAGES)) u_scl_sync (
    .i_clk  (i_clk),
    .i_nrst (i_nrst),
    .pin    (o_scl),
    .level  (scl_s),
    .rise   (scl_rise),
    .fall   (scl_fall)
  );

  i2c_line_sync #(.STAGES(SYNC_STAGES)) u_sda_sync (
    .i_clk  (i_clk),
    .i_nrst (i_nrst),
    .pin    (o_sda),
    .level  (sda_s),
    .rise   (sda_rise),
    .fall   (sda_fall)
  );

  assign start_det = sda_fall & scl_s;
  assign stop_det  = sda_rise & scl_s;

  i2c_tgt_state_t state_q, state_d;
  logic [3:0] bitcnt_q, bitcnt_d;
  logic [7:0] shreg_q, shreg_d;
  logic       addr_match_q, addr_match_d;
  logic       first_q, first_d;
  logic       sda_oe_q, sda_oe_d;
  logic [7:0] rx_data_q, rx_data_d;
  logic       rx_valid_q, rx_valid_d;
  logic       rx_first_q, rx_first_d;
  logic [7:0] byte_cnt_q, byte_cnt_d;
  logic       busy_q, busy_d;
  logic       addr_hit_q, addr_hit_d;

  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      state_q      <= IDLE;
      bitcnt_q     <= 4'd0;
      shreg_q      <= 8'd0;
      addr_match_q <= 1'b0;
      first_q      <= 1'b0;
      sda_oe_q     <= 1'b0;
      rx_data_q    <= 8'd0;
      rx_valid_q   <= 1'b0;
      rx_first_q   <= 1'b0;
      byte_cnt_q   <= 8'd0;
      busy_q       <= 1'b0;
      addr_hit_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      bitcnt_q     <= bitcnt_d;
      shreg_q      <= shreg_d;
      addr_match_q <= addr_match_d;
      first_q      <= first_d;
      sda_oe_q     <= sda_oe_d;
      rx_data_q    <= rx_data_d;
      rx_valid_q   <= rx_valid_d;
      rx_first_q   <= rx_first_d;
      byte_cnt_q   <= byte_cnt_d;
      busy_q       <= busy_d;
      addr_hit_q   <= addr_hit_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    bitcnt_d     = bitcnt_q;
    shreg_d      = shreg_q;
    addr_match_d = addr_match_q;
    first_d      = first_q;
    sda_oe_d     = sda_oe_q;
    rx_data_d    = rx_data_q;
    rx_valid_d   = 1'b0;
    rx_first_d   = 1'b0;
    byte_cnt_d   = byte_cnt_q;
    busy_d       = busy_q;
    addr_hit_d   = addr_hit_q;

    // Bus conditions outrank any SCL edge seen in the same cycle.
    if (start_det) begin
      state_d      = ADDR;
      bitcnt_d     = 4'd0;
      shreg_d      = 8'd0;
      addr_match_d = 1'b0;
      first_d      = 1'b1;
      sda_oe_d     = 1'b0;
      byte_cnt_d   = 8'd0;
      busy_d       = 1'b1;
      addr_hit_d   = 1'b0;
    end else if (stop_det) begin
      state_d    = IDLE;
      bitcnt_d   = 4'd0;
      sda_oe_d   = 1'b0;
      busy_d     = 1'b0;
      addr_hit_d = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: ;

        ADDR: begin
          if (scl_rise && bitcnt_q < BITS_PER_BYTE) begin
            shreg_d  = {shreg_q[6:0], sda_s};
            bitcnt_d = bitcnt_q + 4'd1;
            if (bitcnt_q == 4'(ADDR_W - 1))
              addr_match_d = ({shreg_q[ADDR_W-2:0], sda_s} == i_own_addr);
          end else if (scl_fall && bitcnt_q == BITS_PER_BYTE) begin
            if (addr_match_q && shreg_q[0] == I2C_RW_WRITE) begin
              state_d  = ADDR_ACK;
              sda_oe_d = 1'b1;
            end else begin
              state_d  = IGNORE;
              sda_oe_d = 1'b0;
            end
          end
        end

        ADDR_ACK: begin
          if (scl_fall) begin
            state_d    = DATA;
            bitcnt_d   = 4'd0;
            sda_oe_d   = 1'b0;
            addr_hit_d = 1'b1;
          end
        end

        DATA: begin
          if (scl_rise && bitcnt_q < BITS_PER_BYTE) begin
            shreg_d  = {shreg_q[6:0], sda_s};
            bitcnt_d = bitcnt_q + 4'd1;
          end else if (scl_fall && bitcnt_q == BITS_PER_BYTE) begin
            if (i_rx_ready) begin
              state_d    = DATA_ACK;
              sda_oe_d   = 1'b1;
              rx_data_d  = shreg_q;
              rx_valid_d = 1'b1;
              rx_first_d = first_q;
              first_d    = 1'b0;
              byte_cnt_d = sat_inc8(byte_cnt_q);
            end else begin
              state_d  = IGNORE;
              sda_oe_d = 1'b0;
            end
          end
        end

        DATA_ACK: begin
          if (scl_fall) begin
            state_d  = DATA;
            bitcnt_d = 4'd0;
            sda_oe_d = 1'b0;
          end
        end

        IGNORE: sda_oe_d = 1'b0;

        default: begin
          state_d  = IDLE;
          sda_oe_d = 1'b0;
        end
      endcase
    end
  end

  // Open-drain: the target only ever pulls SDA low; SCL is never driven.
  assign o_sda = sda_oe_q ? I2C_ACK : 1'bz;

  assign o_rx_data  = rx_data_q;
  assign o_rx_valid = rx_valid_q;
  assign o_rx_first = rx_first_q;
  assign o_byte_cnt = byte_cnt_q;
  assign o_busy     = busy_q;
  assign o_addr_hit = addr_hit_q;

endmodule
